instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter RESET_INSTR, default 32'h0000_0013, is the instruction value (RV32I NOP) presented after reset.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pc_i  in  32  byte address of the instruction to fetch.
REQ-005 pc_i_valid  in  1  pc_i holds a fetch request this cycle.
REQ-006 stall_i  in  1  downstream pipeline stall; blocks issue and freezes instruction_o_w.
REQ-007 STALL_if_not_ready_w  out  1  fetch not complete; pipeline must hold.
REQ-008 instruction_o_w  out  32  fetched instruction.
REQ-009 data_req_o_w  out  1  memory request.
REQ-010 data_addr_o_w  out  32  word-aligned request address.
REQ-011 data_we_o_w, data_be_o_w, data_wdata_o_w  out  1/4/32  write enable, byte enables, write data.
REQ-012 data_rdata_i  in  32  read data, valid when data_rvalid_i=1.
REQ-013 data_rvalid_i  in  1  response valid.
REQ-014 data_gnt_i  in  1  request accepted this cycle; may be combinational from data_req_o_w.

Function
REQ-015 data_we_o_w SHALL be 0, data_be_o_w 4'hF and data_wdata_o_w 0 at all times.
REQ-016 FSM states: IDLE, REQ (request waiting for grant, address latched), WAIT_RV (one granted request outstanding).
REQ-017 An issue SHALL be attempted when pc_i_valid=1, stall_i=0 and either state=IDLE or (state=WAIT_RV and data_rvalid_i=1).
REQ-018 An attempted issue SHALL drive data_req_o_w=1 and data_addr_o_w={pc_i[31:2],2'b00} in the same cycle (combinational).
REQ-019 An attempted issue SHALL go to WAIT_RV if data_gnt_i=1; otherwise it SHALL latch the address and go to REQ.
REQ-020 In REQ: data_req_o_w=1 with the latched address, stable until data_gnt_i=1, then go to WAIT_RV; pc_i and stall_i are ignored.
REQ-021 In WAIT_RV: rvalid=0 -> stay, no request; rvalid=1 -> capture data_rdata_i into instr_q, then issue per REQ-017 or go to IDLE.
REQ-022 At most one request SHALL be outstanding; back-to-back issue with a 1-cycle memory gives one fetch per cycle.
REQ-023 data_rvalid_i in IDLE or REQ is spurious and SHALL be ignored.
REQ-024 With stall_i=0: instruction_o_w = data_rdata_i if data_rvalid_i=1, else instr_q (zero-cycle bypass).
REQ-025 With stall_i=1: instruction_o_w = hold_q, the value driven in the last cycle with stall_i=0.
REQ-026 hold_q SHALL load instruction_o_w in every cycle with stall_i=0.
REQ-027 A response arriving while stall_i=1 SHALL still update instr_q; it appears on instruction_o_w after stall_i falls.
REQ-028 STALL_if_not_ready_w = (state==REQ) | (state==WAIT_RV & ~data_rvalid_i) | (issue attempted & ~data_gnt_i).
REQ-029 pc_i presented while stall_i=1 or while blocked SHALL NOT be queued; upstream re-presents it.

Reset
REQ-030 reset SHALL force state=IDLE, instr_q=hold_q=RESET_INSTR and data_req_o_w=0 from the next edge; with stall_i=0, instruction_o_w=RESET_INSTR.
REQ-031 Reset mid-operation SHALL drop any outstanding request; a data_rvalid_i in the first cycle after reset SHALL be ignored.
REQ-032 During reset, no request SHALL issue regardless of pc_i_valid.

Verification
All scenarios use mem[1]=A, mem[2]=B, mem[3]=C, mem[4]=D, data_gnt_i=data_req_o_w and a registered 1-cycle memory with rvalid one cycle after req.
REQ-033 Reset, then idle -> instruction_o_w=32'h13, data_req_o_w=0, STALL_if_not_ready_w=0.
REQ-034 One-cycle pc_i=0x4 with pc_i_valid -> req with addr 0x4 that cycle, instruction_o_w=A next cycle, A held thereafter.
REQ-035 pc_i = 0x4, 0x8, 0x10 on consecutive valid cycles -> one req per cycle; A, B, D each appear one cycle later; stall output stays 0.
REQ-036 stall_i=1 for 2 cycles while pc_i=0xC is valid, one response in flight -> no req during the stall; output frozen; held data presented after stall_i falls.
REQ-037 data_gnt_i held 0 for 3 cycles after an issue at 0x8 -> req and address 0x8 stable; STALL_if_not_ready_w=1 until the grant, then B delivered.
REQ-038 reset asserted in WAIT_RV -> next cycle IDLE; late rvalid ignored; instruction_o_w=32'h13.

Source files
------------

// File: rtl/instruction_memory_if.sv
// Instruction-fetch memory bus: one request/grant channel plus a read-response channel.
// master = fetch unit, slave = instruction memory.
interface instruction_memory_if;
  logic        data_req_o_w;
  logic [31:0] data_addr_o_w;
  logic        data_we_o_w;
  logic [3:0]  data_be_o_w;
  logic [31:0] data_wdata_o_w;
  logic [31:0] data_rdata_i;
  logic        data_rvalid_i;
  logic        data_gnt_i;

  modport master (
    output data_req_o_w, data_addr_o_w, data_we_o_w, data_be_o_w, data_wdata_o_w,
    input  data_rdata_i, data_rvalid_i, data_gnt_i
  );

  modport slave (
    input  data_req_o_w, data_addr_o_w, data_we_o_w, data_be_o_w, data_wdata_o_w,
    output data_rdata_i, data_rvalid_i, data_gnt_i
  );
endinterface

// File: rtl/instruction_memory.sv
// Instruction fetch unit: single-outstanding read requests to instruction memory,
// zero-cycle response bypass and an output hold register for downstream stalls.
module instruction_memory #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                pc_i,
  input  logic                       pc_i_valid,
  input  logic                       stall_i,
  output logic                       STALL_if_not_ready_w,
  output logic [31:0]                instruction_o_w,
  instruction_memory_if.master       dmem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RV} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] hold_q;
  logic [31:0] pc_aligned;
  logic        gnt;
  logic        resp;
  logic        issue;
  logic        req;
  logic [31:0] addr;
  logic        stall_out;

  assign pc_aligned = pc_i & 32'hFFFF_FFFC;
  assign gnt        = dmem.data_gnt_i;
  // rvalid only counts as a response while a granted request is outstanding
  assign resp       = (state_q == WAIT_RV) & dmem.data_rvalid_i;
  assign issue      = pc_i_valid & ~stall_i & ~reset & ((state_q == IDLE) | resp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      instr_q <= RESET_INSTR;
      hold_q  <= RESET_INSTR;
    end else begin
      state_q <= state_d;
      if (issue & ~gnt) addr_q <= pc_aligned;
      if (resp) instr_q <= dmem.data_rdata_i;
      if (!stall_i) hold_q <= instruction_o_w;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = gnt ? WAIT_RV : REQ;
      REQ:     if (gnt) state_d = WAIT_RV;
      WAIT_RV: begin
        if (dmem.data_rvalid_i) begin
          if (issue) state_d = gnt ? WAIT_RV : REQ;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req       = 1'b0;
    addr      = pc_aligned;
    stall_out = 1'b0;
    case (state_q)
      IDLE: begin
        req       = issue;
        stall_out = issue & ~gnt;
      end
      REQ: begin
        req       = ~reset;
        addr      = addr_q;
        stall_out = 1'b1;
      end
      WAIT_RV: begin
        req       = issue;
        stall_out = ~dmem.data_rvalid_i | (issue & ~gnt);
      end
      default: ;
    endcase
  end

  assign dmem.data_req_o_w   = req;
  assign dmem.data_addr_o_w  = addr;
  assign dmem.data_we_o_w    = 1'b0;
  assign dmem.data_be_o_w    = 4'hF;
  assign dmem.data_wdata_o_w = '0;

  assign STALL_if_not_ready_w = stall_out;
  assign instruction_o_w = stall_i ? hold_q : (resp ? dmem.data_rdata_i : instr_q);

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory against a registered 1-cycle memory
// (rvalid one cycle after a granted request).
module tb_instruction_memory;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA  = 32'h1111_AAAA;
  localparam logic [31:0] IB  = 32'h2222_BBBB;
  localparam logic [31:0] IC  = 32'h3333_CCCC;
  localparam logic [31:0] ID  = 32'h4444_DDDD;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        pc_i_valid;
  logic        stall_i;
  logic        STALL_if_not_ready_w;
  logic [31:0] instruction_o_w;
  logic        gnt_block;
  logic        spur;
  logic        mem_rv = 1'b0;
  logic [31:0] mem_rd = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  instruction_memory_if bus ();

  instruction_memory #(.RESET_INSTR(32'h0000_0013)) dut (
    .clk                  (clk),
    .reset                (reset),
    .pc_i                 (pc_i),
    .pc_i_valid           (pc_i_valid),
    .stall_i              (stall_i),
    .STALL_if_not_ready_w (STALL_if_not_ready_w),
    .instruction_o_w      (instruction_o_w),
    .dmem                 (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h4:   return IA;
      32'h8:   return IB;
      32'hC:   return IC;
      32'h10:  return ID;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.data_gnt_i    = bus.data_req_o_w & ~gnt_block;
  assign bus.data_rvalid_i = mem_rv | spur;
  assign bus.data_rdata_i  = spur ? BAD : mem_rd;

  always @(posedge clk) begin
    mem_rv <= bus.data_req_o_w & bus.data_gnt_i;
    mem_rd <= mem_f(bus.data_addr_o_w);
  end

  typedef struct {
    string       nm;
    logic        rst, vld, stl, gblk, sp;
    logic [31:0] pc;
    logic [3:0]  mask;   // {req, addr, stall_out, instr}
    logic        ereq;
    logic [31:0] eaddr;
    logic        estl;
    logic [31:0] einstr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic rst, vld, stl, gblk, sp,
                     input logic [31:0] pc, input logic [3:0] m, input logic er,
                     input logic [31:0] ea, input logic es, input logic [31:0] ei);
    vec_t v;
    v.nm = nm; v.rst = rst; v.vld = vld; v.stl = stl; v.gblk = gblk; v.sp = sp;
    v.pc = pc; v.mask = m; v.ereq = er; v.eaddr = ea; v.estl = es; v.einstr = ei;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    reset = v.rst; pc_i_valid = v.vld; stall_i = v.stl;
    gnt_block = v.gblk; spur = v.sp; pc_i = v.pc;
    #2;
    if (v.mask[3]) chk({v.nm, ".req"}, {31'd0, bus.data_req_o_w}, {31'd0, v.ereq});
    if (v.mask[2]) chk({v.nm, ".addr"}, bus.data_addr_o_w, v.eaddr);
    if (v.mask[1]) chk({v.nm, ".stall"}, {31'd0, STALL_if_not_ready_w}, {31'd0, v.estl});
    if (v.mask[0]) chk({v.nm, ".instr"}, instruction_o_w, v.einstr);
    chk({v.nm, ".const"}, {bus.data_we_o_w, bus.data_be_o_w, bus.data_wdata_o_w[26:0]},
        {1'b0, 4'hF, 27'd0});
  endtask

  initial begin
    reset = 1'b1; pc_i_valid = 1'b0; stall_i = 1'b0; gnt_block = 1'b0; spur = 1'b0; pc_i = '0;

    //   name      rst vld stl gb sp  pc      mask  req addr    stl instr
    add("rst_req", 1, 1, 0, 0, 0, 32'h4,  4'h8, 0, 32'h0,  0, NOP);
    add("rst_st",  1, 0, 0, 0, 0, 32'h0,  4'hB, 0, 32'h0,  0, NOP);
    add("idle",    0, 0, 0, 0, 0, 32'h0,  4'hB, 0, 32'h0,  0, NOP);
    add("one_iss", 0, 1, 0, 0, 0, 32'h4,  4'hF, 1, 32'h4,  0, NOP);
    add("one_A",   0, 0, 0, 0, 0, 32'h0,  4'hB, 0, 32'h0,  0, IA);
    add("one_hA",  0, 0, 0, 0, 0, 32'h0,  4'hB, 0, 32'h0,  0, IA);
    add("one_hA2", 0, 0, 0, 0, 0, 32'h0,  4'h1, 0, 32'h0,  0, IA);
    add("b2b_4",   0, 1, 0, 0, 0, 32'h4,  4'hF, 1, 32'h4,  0, IA);
    add("b2b_8",   0, 1, 0, 0, 0, 32'h8,  4'hF, 1, 32'h8,  0, IA);
    add("b2b_10",  0, 1, 0, 0, 0, 32'h11, 4'hF, 1, 32'h10, 0, IB);
    add("b2b_D",   0, 0, 0, 0, 0, 32'h0,  4'hB, 0, 32'h0,  0, ID);
    add("b2b_hD",  0, 0, 0, 0, 0, 32'h0,  4'h1, 0, 32'h0,  0, ID);
    add("stl_iss", 0, 1, 0, 0, 0, 32'h4,  4'hF, 1, 32'h4,  0, ID);
    add("stl_1",   0, 1, 1, 0, 0, 32'hC,  4'hB, 0, 32'h0,  0, ID);
    add("stl_2",   0, 1, 1, 0, 0, 32'hC,  4'hB, 0, 32'h0,  0, ID);
    add("stl_rel", 0, 1, 0, 0, 0, 32'hC,  4'hF, 1, 32'hC,  0, IA);
    add("stl_C",   0, 0, 0, 0, 0, 32'h0,  4'hB, 0, 32'h0,  0, IC);
    add("gnt_0",   0, 1, 0, 1, 0, 32'h8,  4'hF, 1, 32'h8,  1, IC);
    add("gnt_1",   0, 1, 0, 1, 0, 32'h10, 4'hF, 1, 32'h8,  1, IC);
    add("gnt_2",   0, 0, 0, 1, 0, 32'h0,  4'hF, 1, 32'h8,  1, IC);
    add("gnt_ok",  0, 0, 0, 0, 0, 32'h0,  4'hF, 1, 32'h8,  1, IC);
    add("gnt_B",   0, 0, 0, 0, 0, 32'h0,  4'hB, 0, 32'h0,  0, IB);
    add("gnt_hB",  0, 0, 0, 0, 0, 32'h0,  4'h1, 0, 32'h0,  0, IB);
    add("rw_iss",  0, 1, 0, 0, 0, 32'h4,  4'hF, 1, 32'h4,  0, IB);
    add("rw_rst",  1, 1, 0, 0, 0, 32'h8,  4'h8, 0, 32'h0,  0, NOP);
    add("rw_late", 0, 0, 0, 0, 1, 32'h0,  4'hB, 0, 32'h0,  0, NOP);
    add("rw_idle", 0, 0, 0, 0, 0, 32'h0,  4'hB, 0, 32'h0,  0, NOP);

    foreach (vecs[i]) step(vecs[i]);

    // Spurious rvalid while a request is still waiting for its grant
    begin
      vec_t v;
      v = '{"sp_iss", 0, 1, 0, 1, 0, 32'h10, 4'hF, 1, 32'h10, 1, NOP}; step(v);
      v = '{"sp_rv",  0, 0, 0, 1, 1, 32'h4,  4'hF, 1, 32'h10, 1, NOP}; step(v);
      v = '{"sp_gnt", 0, 0, 0, 0, 0, 32'h4,  4'hF, 1, 32'h10, 1, NOP}; step(v);
      v = '{"sp_D",   0, 0, 0, 0, 0, 32'h0,  4'hB, 0, 32'h0,  0, ID};  step(v);
      v = '{"sp_hD",  0, 0, 0, 0, 0, 32'h0,  4'h1, 0, 32'h0,  0, ID};  step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
